// File: rtl/counter_pkg.sv
// Shared types and elaboration-time helpers for the modulo counter and its prescaler.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } count_mode_e;

    // A one-bit prescaler register is kept even for PRESCALE=1 so the port widths stay legal.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

    function automatic bit params_ok(input int n, input int modulus, input int prescale);
        return (n >= 1) && (n <= 31) && (modulus >= 2) && (modulus <= (1 << n)) && (prescale >= 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Counts enabled cycles and emits a tick on the last cycle of each PRESCALE-long interval.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = prescale_width(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with wrap or saturate at the boundary, clamped load and a prescaled step.
module mod_counter
    import counter_pkg::*;
#(
    parameter int N        = 3,
    parameter int MODULUS  = 2**N,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf
);

    if (!params_ok(N, MODULUS, PRESCALE)) begin : g_param_err
        $error("mod_counter: illegal parameters N=%0d MODULUS=%0d PRESCALE=%0d", N, MODULUS, PRESCALE);
    end

    localparam logic [N-1:0] MAX_VAL = N'(MODULUS - 1);
    localparam count_mode_e  MODE    = (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP;

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic         ovf_q;
    logic         ovf_d;
    logic         tick;
    logic         step;

    // Load clears the prescaler so a fresh interval starts from the loaded value.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (load),
        .tick    (tick)
    );

    assign step  = en & tick;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = up ? (count_q == MAX_VAL) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (up) begin
                if (count_q == MAX_VAL) begin
                    ovf_d = 1'b1;
                    if (MODE == MODE_WRAP) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + N'(1);
                end
            end else begin
                if (count_q == '0) begin
                    ovf_d = 1'b1;
                    if (MODE == MODE_WRAP) begin
                        count_d = MAX_VAL;
                    end
                end else begin
                    count_d = count_q - N'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Directed checks of four counter configurations sharing one clock and one reset.
module tb_mod_counter;

    logic clk;
    logic reset_n;

    logic       en_a, up_a, load_a, tc_a, ovf_a;
    logic [2:0] load_val_a, count_a;
    logic       en_b, up_b, load_b, tc_b, ovf_b;
    logic [2:0] load_val_b, count_b;
    logic       en_c, up_c, load_c, tc_c, ovf_c;
    logic [2:0] load_val_c, count_c;
    logic       en_d, up_d, load_d, tc_d, ovf_d;
    logic [2:0] load_val_d, count_d;

    int errors;
    int checks;

    mod_counter u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .up(up_a), .load(load_a),
        .load_val(load_val_a), .count(count_a), .tc(tc_a), .ovf(ovf_a)
    );

    mod_counter #(.N(3), .MODULUS(6), .SATURATE(0), .PRESCALE(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .up(up_b), .load(load_b),
        .load_val(load_val_b), .count(count_b), .tc(tc_b), .ovf(ovf_b)
    );

    mod_counter #(.N(3), .MODULUS(6), .SATURATE(1), .PRESCALE(1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .en(en_c), .up(up_c), .load(load_c),
        .load_val(load_val_c), .count(count_c), .tc(tc_c), .ovf(ovf_c)
    );

    mod_counter #(.N(3), .MODULUS(8), .SATURATE(0), .PRESCALE(3)) u_dut_d (
        .clk(clk), .reset_n(reset_n), .en(en_d), .up(up_d), .load(load_d),
        .load_val(load_val_d), .count(count_d), .tc(tc_d), .ovf(ovf_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0d at t=%0t", tag, obs, $time);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Expected tables, hand-derived.
    int exp_b_cnt [7] = '{5, 4, 3, 2, 1, 0, 5};
    int exp_b_ovf [7] = '{1, 0, 0, 0, 0, 0, 1};
    int exp_c_cnt [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
    int exp_c_ovf [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    int exp_d_run [4] = '{0, 0, 1, 1};
    int exp_d_res [5] = '{1, 2, 2, 2, 3};

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        en_a = 1'b1; up_a = 1'b1; load_a = 1'b0; load_val_a = '0;
        en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; load_val_b = '0;
        en_c = 1'b0; up_c = 1'b1; load_c = 1'b0; load_val_c = '0;
        en_d = 1'b0; up_d = 1'b1; load_d = 1'b0; load_val_d = '0;

        #3;
        check_eq("reset count_a", count_a, 0);
        check_eq("reset ovf_a", ovf_a, 0);
        check_eq("reset tc_a up=1", tc_a, 0);
        check_eq("reset tc_b up=0", tc_b, 1);
        #4 reset_n = 1'b1;

        // Default counter wraps 7->0 with a single ovf pulse.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("A count[%0d]", i), count_a, i % 8);
            check_eq($sformatf("A ovf[%0d]", i), ovf_a, (i == 8) ? 1 : 0);
            check_eq($sformatf("A tc[%0d]", i), tc_a, ((i % 8) == 7) ? 1 : 0);
        end
        en_a = 1'b0;

        // MODULUS=6 wrap, counting down from 0.
        check_eq("B tc at 0 down", tc_b, 1);
        en_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_eq($sformatf("B count[%0d]", i), count_b, exp_b_cnt[i]);
            check_eq($sformatf("B ovf[%0d]", i), ovf_b, exp_b_ovf[i]);
            check_eq($sformatf("B tc[%0d]", i), tc_b, (exp_b_cnt[i] == 0) ? 1 : 0);
        end
        en_b = 1'b0;

        // MODULUS=6 saturate, counting up and holding at 5.
        en_c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("C count[%0d]", i), count_c, exp_c_cnt[i]);
            check_eq($sformatf("C ovf[%0d]", i), ovf_c, exp_c_ovf[i]);
            check_eq($sformatf("C tc[%0d]", i), tc_c, (exp_c_cnt[i] == 5) ? 1 : 0);
        end
        en_c = 1'b0;
        @(negedge clk);
        check_eq("C hold count", count_c, 5);
        check_eq("C ovf after en drop", ovf_c, 0);

        // PRESCALE=3 with en dropped mid-interval.
        en_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("D run count[%0d]", i), count_d, exp_d_run[i]);
        end
        en_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("D frozen count[%0d]", i), count_d, 1);
        end
        en_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("D resume count[%0d]", i), count_d, exp_d_res[i]);
        end

        // Clamped load with en=1 on a MODULUS=6 counter: no step, no ovf.
        up_b = 1'b1; en_b = 1'b1; load_b = 1'b1; load_val_b = 3'd7;
        @(negedge clk);
        load_b = 1'b0; en_b = 1'b0;
        check_eq("E load clamp count_b", count_b, 5);
        check_eq("E load ovf_b", ovf_b, 0);
        check_eq("E load tc_b", tc_b, 1);

        // Load clears the prescaler: dut_d is one cycle into an interval here.
        @(negedge clk);
        check_eq("E pre-load count_d", count_d, 3);
        load_d = 1'b1; load_val_d = 3'd2;
        @(negedge clk);
        load_d = 1'b0;
        check_eq("E load count_d", count_d, 2);
        @(negedge clk);
        @(negedge clk);
        check_eq("E prescaler cleared count_d", count_d, 2);
        @(negedge clk);
        check_eq("E first tick after load", count_d, 3);
        en_d = 1'b0;

        // Asynchronous reset between edges at count 4.
        en_a = 1'b1;
        en_c = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check_eq("F count_a before reset", count_a, 4);
        check_eq("F ovf_c before reset", ovf_c, 1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("F async count_a", count_a, 0);
        check_eq("F async ovf_a", ovf_a, 0);
        check_eq("F async ovf_c", ovf_c, 0);
        check_eq("F async count_c", count_c, 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("F restart count_a[0]", count_a, 1);
        @(negedge clk);
        check_eq("F restart count_a[1]", count_a, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
